// File: rtl/mux_scan_capture_pkg.sv
// Shared types and helpers for the dual 1-of-4 mux scan/capture sequencer.
package mux_scan_capture_pkg;

  localparam int unsigned NPOS  = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } scan_state_e;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [0:NPOS-1]  word4_t;

  typedef struct packed {
    logic found;
    sel_t pos;
  } pos_t;

  // Lowest enabled position strictly above cur.
  function automatic pos_t next_pos(word4_t mask, sel_t cur);
    pos_t r;
    r.found = 1'b0;
    r.pos   = '0;
    for (int i = 0; i < NPOS; i++) begin
      if (!r.found && (i > int'(cur)) && mask[sel_t'(i)]) begin
        r.found = 1'b1;
        r.pos   = sel_t'(i);
      end
    end
    return r;
  endfunction

  // Lowest enabled position, including position 0.
  function automatic pos_t first_pos(word4_t mask);
    pos_t r;
    if (mask[0]) begin
      r.found = 1'b1;
      r.pos   = '0;
    end else begin
      r = next_pos(mask, '0);
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_capture_settle_ctr.sv
// Settle-delay counter: load, decrement to zero, registered zero flag.
module mux_scan_capture_settle_ctr
  import mux_scan_capture_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/mux_scan_capture.sv
// Drives SEL/EN of a dual 1-of-4 mux over the enabled positions and
// reassembles the B0/B1 samples into words W0/W1 behind a valid/ready port.
module mux_scan_capture
  import mux_scan_capture_pkg::*;
#(
  parameter int unsigned SETTLE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [0:3] mask,
  input  logic       abort,
  output logic [0:1] SEL,
  output logic       EN,
  input  logic       B0,
  input  logic       B1,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [0:3] W0,
  output logic [0:3] W1
);

  localparam bit               HAS_SETTLE = (SETTLE != 0);
  localparam logic [CNT_W-1:0] LOAD_VAL   = CNT_W'(HAS_SETTLE ? SETTLE - 1 : 0);
  localparam scan_state_e      VISIT_ST   = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;

  scan_state_e state_q, state_d;
  sel_t        sel_q, sel_d;
  logic        en_q, busy_q, valid_q, busy_d, valid_d;
  word4_t      mask_q, mask_d;
  word4_t      sh0_q, sh0_d, sh1_q, sh1_d, sh0_upd, sh1_upd;
  word4_t      w0_q, w0_d, w1_q, w1_d;
  logic        ctr_load, ctr_dec, ctr_zero;
  pos_t        first_c, next_c;

  assign first_c = first_pos(mask);
  assign next_c  = next_pos(mask_q, sel_q);

  mux_scan_capture_settle_ctr u_settle_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ctr_load),
    .load_val_i (LOAD_VAL),
    .dec_i      (ctr_dec),
    .zero_o     (ctr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort only matters while scanning; start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = first_c.found ? VISIT_ST : ST_DONE;
      ST_SETTLE: begin
        if (abort)         state_d = ST_IDLE;
        else if (ctr_zero) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (abort) state_d = ST_IDLE;
        else       state_d = next_c.found ? VISIT_ST : ST_DONE;
      end
      ST_DONE:   if (out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of the select, capture shadows and result words.
  always_comb begin
    mask_d   = mask_q;
    sel_d    = sel_q;
    sh0_d    = sh0_q;
    sh1_d    = sh1_q;
    w0_d     = w0_q;
    w1_d     = w1_q;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    sh0_upd  = sh0_q;
    sh1_upd  = sh1_q;
    sh0_upd[sel_q] = B0;
    sh1_upd[sel_q] = B1;
    busy_d   = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    valid_d  = (state_d == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d   = mask;
          sh0_d    = '0;
          sh1_d    = '0;
          sel_d    = first_c.pos;
          ctr_load = first_c.found;
          if (!first_c.found) begin
            w0_d = '0;
            w1_d = '0;
          end
        end
      end
      ST_SETTLE: begin
        if (abort) sel_d = '0;
        else       ctr_dec = !ctr_zero;
      end
      ST_SAMPLE: begin
        if (abort) begin
          sel_d = '0;
        end else begin
          sh0_d = sh0_upd;
          sh1_d = sh1_upd;
          if (next_c.found) begin
            sel_d    = next_c.pos;
            ctr_load = 1'b1;
          end else begin
            w0_d  = sh0_upd;
            w1_d  = sh1_upd;
            sel_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      mask_q  <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
    end else begin
      sel_q   <= sel_d;
      en_q    <= busy_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      mask_q  <= mask_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
    end
  end

  assign SEL       = sel_q;
  assign EN        = en_q;
  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign W0        = w0_q;
  assign W1        = w1_q;

endmodule

// File: doc/mux_scan_capture.md
Name: mux_scan_capture

Overview:
- Sequencer that drives the SEL/EN inputs of a dual 1-of-4 mux and captures its B0/B1 outputs.
- Each scan visits positions 0..3 and reassembles the two 4-bit mux data inputs into words W0/W1, so W0[i] is D0[i] and W1[i] is D1[i].
- Sits beside the mux: it feeds the select side and consumes the data side.
- Results leave through a valid/ready handshake to the consumer stage.

Parameters:
- SETTLE, 0, number of wait cycles after SEL/EN change before B0/B1 are sampled (0..15).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a scan; honoured only in IDLE.
- mask  in  [0:3]  per-position enable, latched at start; mask[i]=0 means position i is skipped and its captured bit is 0.
- abort  in  1  cancels a scan in progress.
- SEL  out  [0:1]  mux select.
- EN  out  1  mux enable.
- B0  in  1  mux output, bank 0.
- B1  in  1  mux output, bank 1.
- busy  out  1  high from the cycle after start is accepted until the return to IDLE or DONE.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- W0  out  [0:3]  captured bank-0 word.
- W1  out  [0:3]  captured bank-1 word.

Behaviour:
- Reset (async, rst_n=0): state IDLE, SEL=0, EN=0, busy=0, out_valid=0, W0=0, W1=0, internal mask=0, settle count=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 latches mask and clears the W0/W1 shadow capture registers.
  - Goes to the first unmasked position p: SEL=p, EN=1.
  - Enters SETTLE when SETTLE>0, otherwise SAMPLE.
  - If the latched mask is 0000, goes directly to DONE with W0=W1=0; out_valid is high the cycle after start.
- SETTLE: counts SETTLE cycles with SEL/EN held, then goes to SAMPLE.
- SAMPLE:
  - At the clock edge, shadow0[SEL]<=B0 and shadow1[SEL]<=B1.
  - Then advances to the next unmasked position above SEL (SEL updated, EN stays 1, back to SETTLE or SAMPLE).
  - If no unmasked position remains: copy the shadows to W0/W1, set EN=0 and SEL=0, go to DONE.
- Per-position cost is SETTLE+1 cycles.
  - Full mask, SETTLE=0: out_valid is high 5 cycles after the start edge (4 samples plus 1).
  - General case: out_valid rises one cycle after the last SAMPLE.
- DONE:
  - out_valid=1, and W0/W1 are stable while out_valid=1.
  - out_valid&&out_ready returns to IDLE next cycle with out_valid=0.
  - W0/W1 retain their values until the next completed scan.
- EN is high only in SETTLE/SAMPLE. SEL never changes while EN=1 except at a SAMPLE edge.
- start while busy or in DONE is ignored, including start in the handshake cycle.
- abort in SETTLE/SAMPLE:
  - Next state IDLE, EN=0, SEL=0, no out_valid.
  - W0/W1 keep the previous result.
  - abort in IDLE or DONE has no effect.
  - abort and start together in IDLE: start wins.
- Reset asserted mid-scan forces the reset values immediately (async), with no partial result.
- B0/B1 are assumed to meet setup to clk in the SAMPLE cycle. No synchronisation is performed.

Decomposition:
- Shared package holds:
  - scan state enum (IDLE, SETTLE, SAMPLE, DONE)
  - sel_t (2-bit)
  - word4_t (4-bit)
  - the function next_pos(mask, cur) returning {found, pos}
- One natural sub-module: settle_ctr (load/decrement/zero-flag counter, width 4), instantiated once.

Test Plan:
- Bench instantiates the real dual 4-to-1 mux with D0=1010, D1=0110, SETTLE=0, mask=1111, start pulse. Required response:
  - SEL sequence 0,1,2,3, each for 1 cycle, with EN=1.
  - out_valid at start+5, W0=1010, W1=0110.
  - out_valid held while out_ready=0 for 3 cycles; drops the cycle after out_ready=1.
- SETTLE=2, mask=0101, D0=1111, D1=0001. Required response:
  - Only SEL=1 and SEL=3 are visited, 3 cycles each.
  - W0=0101, W1=0001, out_valid at start+7.
- mask=0000 -> out_valid the cycle after start, W0=W1=0, EN never high.
- abort during the SEL=2 SAMPLE of a second scan (first scan gave W0=1010) -> IDLE next cycle, EN=0, out_valid stays 0, W0 still 1010.
- start pulsed while busy and during the DONE handshake cycle -> ignored; exactly one out_valid per accepted start.
- rst_n driven low asynchronously mid-SETTLE -> SEL=0, EN=0, busy=0, W0=W1=0 without waiting for a clk edge; a new scan after release completes normally.
